// File: rtl/mux_bus_pkg.sv
// mux_bus_pkg
//   Shared definitions for the multiplexed SRAM bus responder: data width,
//   default address width and synchronizer depth, and the bus FSM states.
package mux_bus_pkg;

    localparam int DATA_W          = 8;
    localparam int ADDR_W_DEF      = 15;
    localparam int SYNC_STAGES_DEF = 2;

    // IDLE : no valid address held
    // ADDR : le asserted, address being captured
    // READY: address held, reads served, waiting for a write strobe
    // WRITE: we_n low, data being captured
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READY = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/mux_bus_responder_strobe_sync.sv
// strobe_sync
//   N-stage synchronizer for one asynchronous control strobe, with single-cycle
//   rise/fall pulses derived from the synchronized level.
//
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset
//   d     in  1  raw asynchronous strobe
//   q     out 1  synchronized level (STAGES cycles behind d)
//   rise  out 1  high for one cycle when q goes 0 -> 1
//   fall  out 1  high for one cycle when q goes 1 -> 0
module strobe_sync #(
    parameter int   STAGES    = 2,     // must be >= 2
    parameter logic RESET_VAL = 1'b0   // inactive level of the strobe
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              q_prev;

    // Reset to the inactive level so that leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            q_prev <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous value of its neighbour, which is what forms the chain.
            sync_q <= {sync_q[STAGES-2:0], d};
            q_prev <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~q_prev;
    assign fall = ~q &  q_prev;

endmodule

// File: rtl/mux_bus_responder.sv
// mux_bus_responder
//   Clocked memory end of the host multiplexed SRAM bus. Low address and data
//   share ad_in; high address arrives on addr_hi. All inputs are synchronized
//   through equal-depth pipelines, decoded by a single FSM, and bytes are
//   stored in an internal 2^ADDR_W array. Reads return on ad_out/ad_oe.
//
//   clk        in  1         clock
//   rst        in  1         asynchronous active-high reset
//   ad_in      in  8         low address (latch phase) / write data
//   addr_hi    in  ADDR_W-8  high address bits
//   le         in  1         address latch enable, active-high
//   we_n       in  1         write strobe, active-low
//   cs_n       in  1         chip select, active-low
//   oe_n       in  1         read output enable, active-low
//   ad_out     out 8         read data (8'h00 when not driving)
//   ad_oe      out 1         block drives ad_out onto the bus
//   wr_done    out 1         one-cycle pulse per committed write
//   proto_err  out 1         sticky protocol error, cleared only by rst
module mux_bus_responder
    import mux_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF   // must be >= 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   ad_in,
    input  logic [ADDR_W-9:0]   addr_hi,
    input  logic                le,
    input  logic                we_n,
    input  logic                cs_n,
    input  logic                oe_n,
    output logic [DATA_W-1:0]   ad_out,
    output logic                ad_oe,
    output logic                wr_done,
    output logic                proto_err
);

    localparam int HI_W      = ADDR_W - 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    // ---------------------------------------------------------------
    // Input synchronization: buses and strobes share the same depth so
    // a strobe edge and the bus value it accompanies arrive together.
    // ---------------------------------------------------------------
    logic le_q, le_rise, unused_le_fall;
    logic we_q, we_rise, we_fall;
    logic cs_q, unused_cs_rise, unused_cs_fall;
    logic oe_q, unused_oe_rise, unused_oe_fall;

    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_le_sync (
        .clk(clk), .rst(rst), .d(le),   .q(le_q), .rise(le_rise),        .fall(unused_le_fall));
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_we_sync (
        .clk(clk), .rst(rst), .d(we_n), .q(we_q), .rise(we_rise),        .fall(we_fall));
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_q), .rise(unused_cs_rise), .fall(unused_cs_fall));
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_oe_sync (
        .clk(clk), .rst(rst), .d(oe_n), .q(oe_q), .rise(unused_oe_rise), .fall(unused_oe_fall));

    logic [DATA_W-1:0] ad_pipe [SYNC_STAGES];
    logic [HI_W-1:0]   hi_pipe [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_pipe[i] <= '0;
                hi_pipe[i] <= '0;
            end
        end else begin
            ad_pipe[0] <= ad_in;
            hi_pipe[0] <= addr_hi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_pipe[i] <= ad_pipe[i-1];
                hi_pipe[i] <= hi_pipe[i-1];
            end
        end
    end

    logic [DATA_W-1:0] ad_sync;
    logic [HI_W-1:0]   hi_sync;
    assign ad_sync = ad_pipe[SYNC_STAGES-1];
    assign hi_sync = hi_pipe[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // Bus FSM and registered outputs
    // ---------------------------------------------------------------
    state_t            state;
    logic [7:0]        addr_lo;
    logic [HI_W-1:0]   addr_hi_q;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic              rd_enable;
    logic              commit;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign addr      = {addr_hi_q, addr_lo};
    assign rd_enable = (state == READY) && !cs_q && !oe_q;

    // Mirrors the WRITE-state priority below: an le rise or deselect aborts
    // the write, so only a clean we_n rise commits.
    assign commit = (state == WRITE) && !le_rise && !cs_q && we_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_lo   <= '0;
            addr_hi_q <= '0;
            wdata     <= '0;
            rdata     <= '0;
            wr_done   <= 1'b0;
            proto_err <= 1'b0;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
        end else begin
            wr_done <= 1'b0;
            ad_oe   <= rd_enable;
            ad_out  <= rd_enable ? rdata : '0;

            case (state)
                IDLE: begin
                    if (we_fall) proto_err <= 1'b1;
                    if (le_q) begin
                        state     <= ADDR;
                        addr_lo   <= ad_sync;
                        addr_hi_q <= hi_sync;
                    end
                end

                ADDR: begin
                    if (we_fall) proto_err <= 1'b1;
                    if (le_q) begin
                        addr_lo   <= ad_sync;
                        addr_hi_q <= hi_sync;
                    end else begin
                        // Address stays frozen at the last le-high sample.
                        state <= READY;
                    end
                end

                READY: begin
                    rdata <= mem[addr];
                    if (le_q) begin
                        // A new address always wins; a concurrent write strobe
                        // is flagged rather than silently dropped.
                        state     <= ADDR;
                        addr_lo   <= ad_sync;
                        addr_hi_q <= hi_sync;
                        if (!we_q) proto_err <= 1'b1;
                    end else if (we_fall && !cs_q) begin
                        state <= WRITE;
                        wdata <= ad_sync;
                    end
                end

                WRITE: begin
                    if (le_rise) begin
                        state     <= ADDR;
                        proto_err <= 1'b1;
                        addr_lo   <= ad_sync;
                        addr_hi_q <= hi_sync;
                    end else if (cs_q) begin
                        state <= READY;
                    end else if (we_rise) begin
                        state   <= READY;
                        wr_done <= 1'b1;
                    end else begin
                        // Only low-strobe cycles update wdata; the bus may
                        // already carry the next value on the rising edge.
                        wdata <= ad_sync;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset branch; resetting it would turn the
    // inferred RAM into thousands of flops. Reset only stops commits, since
    // commit is derived from state, which rst forces to IDLE.
    always_ff @(posedge clk) begin
        if (commit) mem[addr] <= wdata;
    end

endmodule

// File: tb/tb_mux_bus_responder.sv
// tb_mux_bus_responder
//   Self-checking bench: directed bus transactions plus a randomized phase,
//   all checked against a byte-level memory model kept in the bench.
module tb_mux_bus_responder;
    import mux_bus_pkg::*;

    localparam int ADDR_W = 15;
    localparam int HI_W   = ADDR_W - 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      ad_in;
    logic [HI_W-1:0] addr_hi;
    logic            le, we_n, cs_n, oe_n;
    logic [7:0]      ad_out;
    logic            ad_oe, wr_done, proto_err;

    int checks = 0;
    int errors = 0;
    int wr_done_cnt = 0;
    int oe_cnt = 0;

    // Reference model: address -> last committed byte.
    logic [7:0] ref_mem [int];
    int         written [$];

    mux_bus_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ad_in(ad_in), .addr_hi(addr_hi),
        .le(le), .we_n(we_n), .cs_n(cs_n), .oe_n(oe_n),
        .ad_out(ad_out), .ad_oe(ad_oe), .wr_done(wr_done), .proto_err(proto_err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_done === 1'b1) wr_done_cnt++;
        if (ad_oe === 1'b1)   oe_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_addr(input logic [HI_W-1:0] hi, input logic [7:0] lo);
        addr_hi = hi;
        ad_in   = lo;
        le      = 1'b1;
        tick($urandom_range(3, 5));
        le      = 1'b0;
        tick(4);
    endtask

    // Drives one data phase; returns the number of wr_done pulses seen.
    task automatic write_phase(input logic [7:0] data, output int pulses);
        int c0;
        c0   = wr_done_cnt;
        ad_in = data;
        we_n  = 1'b0;
        tick($urandom_range(3, 5));
        we_n  = 1'b1;
        tick(6);
        pulses = wr_done_cnt - c0;
    endtask

    task automatic host_write(input string tag, input logic [HI_W-1:0] hi,
                              input logic [7:0] lo, input logic [7:0] data);
        int p;
        int key;
        latch_addr(hi, lo);
        write_phase(data, p);
        check({tag, "_wr_done"}, p, 1);
        key = int'({hi, lo});
        if (!ref_mem.exists(key)) written.push_back(key);
        ref_mem[key] = data;
    endtask

    task automatic host_read(input logic [HI_W-1:0] hi, input logic [7:0] lo,
                             output logic [7:0] data, output logic oe);
        latch_addr(hi, lo);
        oe_n = 1'b0;
        tick(5);
        data = ad_out;
        oe   = ad_oe;
        oe_n = 1'b1;
        tick(4);
    endtask

    task automatic read_check(input string tag, input logic [HI_W-1:0] hi, input logic [7:0] lo);
        logic [7:0] d;
        logic       oe;
        host_read(hi, lo, d, oe);
        check({tag, "_data"}, d, ref_mem[int'({hi, lo})]);
        check({tag, "_oe"}, oe, 1);
    endtask

    initial begin
        logic [7:0] d;
        logic       oe;
        int         p, c0, o0;

        rst = 1'b1; ad_in = '0; addr_hi = '0;
        le = 1'b0; we_n = 1'b1; cs_n = 1'b0; oe_n = 1'b1;
        tick(3);
        check("rst_ad_oe",     ad_oe, 0);
        check("rst_ad_out",    ad_out, 0);
        check("rst_wr_done",   wr_done, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_state",     32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick(2);

        // Low and upper bank write loops.
        for (int i = 0; i < 8; i++) host_write("lo_bank", 7'h00, 8'(i), 8'(7 - i));
        for (int i = 0; i < 8; i++) host_write("hi_bank", 7'h7F, 8'(i), 8'(7 - i));
        for (int i = 0; i < 8; i++) read_check("lo_rd", 7'h00, 8'(i));
        for (int i = 0; i < 8; i++) read_check("hi_rd", 7'h7F, 8'(i));

        // Directed readback of address 3 then release of oe_n.
        latch_addr(7'h00, 8'h03);
        oe_n = 1'b0;
        tick(5);
        check("rd3_data", ad_out, 8'h04);
        check("rd3_oe",   ad_oe, 1);
        oe_n = 1'b1;
        tick(4);
        check("rd3_oe_off", ad_oe, 0);
        check("rd3_out_off", ad_out, 0);

        // Chip deselect in the middle of a write to address 2.
        latch_addr(7'h00, 8'h02);
        c0 = wr_done_cnt;
        o0 = oe_cnt;
        ad_in = 8'hAA;
        we_n  = 1'b0;
        tick(4);
        cs_n  = 1'b1;
        tick(4);
        we_n  = 1'b1;
        tick(4);
        cs_n  = 1'b0;
        tick(4);
        check("desel_wr_done", wr_done_cnt - c0, 0);
        check("desel_oe",      oe_cnt - o0, 0);
        check("desel_err",     proto_err, 0);
        read_check("desel_rd", 7'h00, 8'h02);

        // Randomized legal traffic against the model.
        for (int n = 0; n < 40; n++) begin
            if (($urandom_range(0, 1) == 1) && (written.size() > 0)) begin
                int k;
                k = written[$urandom_range(0, written.size() - 1)];
                read_check("rnd_rd", k[14:8], k[7:0]);
            end else begin
                host_write("rnd", 7'($urandom_range(0, 127)), 8'($urandom), 8'($urandom));
            end
        end
        check("rnd_no_err", proto_err, 0);

        // le rising during a write to address 5: aborted, error flagged.
        latch_addr(7'h00, 8'h05);
        c0 = wr_done_cnt;
        ad_in = 8'hEE;
        we_n  = 1'b0;
        tick(4);
        ad_in = 8'h05;
        le    = 1'b1;
        tick(4);
        le    = 1'b0;
        tick(4);
        we_n  = 1'b1;
        tick(6);
        check("le_abort_err",     proto_err, 1);
        check("le_abort_wr_done", wr_done_cnt - c0, 0);
        read_check("le_abort_rd", 7'h00, 8'h05);

        // Reset in the middle of a read drops ad_oe asynchronously.
        latch_addr(7'h00, 8'h03);
        oe_n = 1'b0;
        tick(5);
        check("mid_rd_oe", ad_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oe",  ad_oe, 0);
        check("async_rst_err", proto_err, 0);
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        oe_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        // Write strobe straight after reset: error, no commit.
        c0 = wr_done_cnt;
        write_phase(8'h55, p);
        check("idle_we_wr_done", p, 0);
        check("idle_we_err",     proto_err, 1);
        // Memory is not reset and the stray strobe changed nothing.
        read_check("post_rst_rd0", 7'h00, 8'h00);
        read_check("post_rst_rd7", 7'h7F, 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
